// File: rtl/spi_address_sequencer.sv
// Address generator for the SPI flash fetch path: loadable base, programmable
// step, bounded wrap between wrap_base and limit, and a counted burst mode.
module spi_address_sequencer #(
  parameter int ADDR_W  = 24,
  parameter int STEP    = 16,
  parameter int LEN_W   = 8,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              initP,
  input  logic              loadP,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              startP,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              incP,
  input  logic [ADDR_W-1:0] limit,
  input  logic [ADDR_W-1:0] wrap_base,
  output logic [ADDR_W-1:0] address,
  output logic [LEN_W-1:0]  remaining,
  output logic              busy,
  output logic              doneP,
  output logic              wrapP
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [ADDR_W:0] STEP_EXT = (ADDR_W+1)'(STEP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              wrap_q, wrap_d;

  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] next_addr;
  logic              wrap_event;

  // The extra sum bit lets limit==0 behave as 2^ADDR_W and exposes the carry.
  always_comb begin
    sum = {1'b0, address_q} + STEP_EXT;
    if (WRAP_EN && (limit != '0)) begin
      wrap_event = (sum >= {1'b0, limit});
      next_addr  = wrap_event ? wrap_base : sum[ADDR_W-1:0];
    end else begin
      wrap_event = sum[ADDR_W];
      next_addr  = sum[ADDR_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    address_d   = address_q;
    remaining_d = remaining_q;
    wrap_d      = 1'b0;
    state_d     = (state_q == ST_DONE) ? ST_IDLE : state_q;

    if (initP) begin
      address_d   = '0;
      remaining_d = '0;
      state_d     = ST_IDLE;
    end else if (loadP) begin
      address_d   = load_addr;
      remaining_d = '0;
      state_d     = ST_IDLE;
    end else if (startP) begin
      // A zero-length burst completes at once and leaves nothing remaining.
      remaining_d = burst_len;
      state_d     = (burst_len != '0) ? ST_RUN : ST_DONE;
    end else if (incP) begin
      address_d = next_addr;
      wrap_d    = wrap_event;
      if (state_q == ST_RUN) begin
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      address_q   <= '0;
      remaining_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      remaining_q <= remaining_d;
      wrap_q      <= wrap_d;
    end
  end

  assign address   = address_q;
  assign remaining = remaining_q;
  assign busy      = (state_q == ST_RUN);
  assign doneP     = (state_q == ST_DONE);
  assign wrapP     = wrap_q;

endmodule

// File: tb/tb_spi_address_sequencer.sv
// Self-checking bench for spi_address_sequencer: directed scenarios from the
// plan plus randomized traffic against a behavioural model.
module tb_spi_address_sequencer;

  localparam int AW   = 24;
  localparam int LW   = 8;
  localparam int STEP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          initP, loadP, startP, incP;
  logic [AW-1:0] load_addr, limit, wrap_base;
  logic [LW-1:0] burst_len;
  logic [AW-1:0] address;
  logic [LW-1:0] remaining;
  logic          busy, doneP, wrapP;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: address as a plain integer, burst as a count plus a
  // "finished last cycle" flag.
  longint m_addr;
  int     m_rem;
  bit     m_running, m_finished, m_wrap;

  spi_address_sequencer #(.ADDR_W(AW), .STEP(STEP), .LEN_W(LW), .WRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .initP(initP), .loadP(loadP), .load_addr(load_addr),
    .startP(startP), .burst_len(burst_len), .incP(incP), .limit(limit),
    .wrap_base(wrap_base), .address(address), .remaining(remaining), .busy(busy),
    .doneP(doneP), .wrapP(wrapP)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_addr = 0; m_rem = 0; m_running = 0; m_finished = 0; m_wrap = 0;
  endfunction

  function automatic void model_cycle(bit i_init, bit i_load, longint i_laddr,
                                      bit i_start, int i_len, bit i_inc,
                                      longint i_limit, longint i_base);
    longint s;
    m_wrap     = 0;
    m_finished = 0;
    if (i_init) begin
      m_addr = 0; m_rem = 0; m_running = 0;
    end else if (i_load) begin
      m_addr = i_laddr; m_rem = 0; m_running = 0;
    end else if (i_start) begin
      m_rem = i_len;
      m_running  = (i_len != 0);
      m_finished = (i_len == 0);
    end else if (i_inc) begin
      s = m_addr + STEP;
      if (i_limit != 0) begin
        if (s >= i_limit) begin m_addr = i_base; m_wrap = 1; end
        else m_addr = s;
      end else begin
        m_wrap = (s >= (64'd1 << AW));
        m_addr = s % (64'd1 << AW);
      end
      if (m_running) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_running = 0; m_finished = 1; end
      end
    end
  endfunction

  // One clock: drive at the falling edge, update the model, sample 1 ns after
  // the rising edge.
  task automatic step(input bit i_init, input bit i_load, input logic [AW-1:0] i_laddr,
                      input bit i_start, input logic [LW-1:0] i_len, input bit i_inc);
    @(negedge clk);
    initP = i_init; loadP = i_load; load_addr = i_laddr;
    startP = i_start; burst_len = i_len; incP = i_inc;
    model_cycle(i_init, i_load, i_laddr, i_start, i_len, i_inc, limit, wrap_base);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    initP = 0; loadP = 0; startP = 0; incP = 0;
    load_addr = '0; burst_len = '0; limit = '0; wrap_base = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if ({address, remaining, busy, doneP, wrapP} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h rem=%0d busy=%b done=%b wrap=%b, want all 0",
               address, remaining, busy, doneP, wrapP);
    end
    n_checks++;
  endtask

  task automatic test_free_inc();
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, '0, 0, '0, 1);
      if (address !== AW'(16 * k) || remaining !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL free_inc_%0d: addr=%h rem=%0d busy=%b, want addr=%h rem=0 busy=0",
                 k, address, remaining, busy, AW'(16 * k));
      end
      n_checks++;
    end
  endtask

  task automatic test_burst();
    step(0, 1, 24'h000100, 0, '0, 0);
    step(0, 0, '0, 1, 8'd4, 0);
    if (address !== 24'h000100 || remaining !== 8'd4 || busy !== 1'b1 || doneP !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_start: addr=%h rem=%0d busy=%b done=%b, want 000100 4 1 0",
               address, remaining, busy, doneP);
    end
    n_checks++;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, '0, 0, '0, 1);
      if (address !== AW'(24'h100 + 16 * k) || remaining !== LW'(4 - k) ||
          busy !== (k < 4) || doneP !== (k == 4)) begin
        n_fail++;
        $display("FAIL burst_inc_%0d: addr=%h rem=%0d busy=%b done=%b, want %h %0d %b %b",
                 k, address, remaining, busy, doneP, AW'(24'h100 + 16 * k), 4 - k,
                 k < 4, k == 4);
      end
      n_checks++;
    end
    idle();
    if (busy !== 1'b0 || doneP !== 1'b0 || address !== 24'h000140) begin
      n_fail++;
      $display("FAIL burst_after: addr=%h busy=%b done=%b, want 000140 0 0", address, busy, doneP);
    end
    n_checks++;
  endtask

  task automatic test_wrap_limit();
    limit = 24'h000200; wrap_base = 24'h000080;
    step(0, 1, 24'h0001F0, 0, '0, 0);
    step(0, 0, '0, 0, '0, 1);
    if (address !== 24'h000080 || wrapP !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_limit: addr=%h wrap=%b, want 000080 1", address, wrapP);
    end
    n_checks++;
    step(0, 0, '0, 0, '0, 1);
    if (address !== 24'h000090 || wrapP !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_limit_next: addr=%h wrap=%b, want 000090 0", address, wrapP);
    end
    n_checks++;
  endtask

  task automatic test_wrap_modulo();
    limit = '0; wrap_base = 24'h000080;
    step(0, 1, 24'hFFFFF0, 0, '0, 0);
    step(0, 0, '0, 0, '0, 1);
    if (address !== 24'h000000 || wrapP !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_modulo: addr=%h wrap=%b, want 000000 1", address, wrapP);
    end
    n_checks++;
    idle();
    if (wrapP !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pulse_len: wrap=%b, want 0", wrapP);
    end
    n_checks++;
  endtask

  task automatic test_priority();
    step(0, 1, 24'h000300, 0, '0, 0);
    step(0, 0, '0, 1, 8'd2, 1);
    if (address !== 24'h000300 || remaining !== 8'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_drops_inc: addr=%h rem=%0d busy=%b, want 000300 2 1",
               address, remaining, busy);
    end
    n_checks++;
    step(1, 0, '0, 0, '0, 0);
    step(0, 0, '0, 1, 8'd0, 0);
    if (doneP !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: done=%b busy=%b, want 1 0", doneP, busy);
    end
    n_checks++;
    idle();
    if (doneP !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_after: done=%b busy=%b, want 0 0", doneP, busy);
    end
    n_checks++;
  endtask

  task automatic test_abort_init();
    step(0, 1, 24'h000400, 0, '0, 0);
    step(0, 0, '0, 1, 8'd5, 0);
    step(0, 0, '0, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    if (remaining !== 8'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: rem=%0d busy=%b, want 3 1", remaining, busy);
    end
    n_checks++;
    step(1, 0, '0, 0, '0, 1);
    if (address !== '0 || remaining !== '0 || busy !== 1'b0 || doneP !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_init: addr=%h rem=%0d busy=%b done=%b, want 0 0 0 0",
               address, remaining, busy, doneP);
    end
    n_checks++;
    idle();
    if (doneP !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done=%b, want 0", doneP);
    end
    n_checks++;
  endtask

  task automatic test_async_reset();
    step(0, 1, 24'h000500, 0, '0, 0);
    step(0, 0, '0, 1, 8'd6, 0);
    step(0, 0, '0, 0, '0, 1);
    @(negedge clk);
    incP = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    if ({address, remaining, busy, doneP, wrapP} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h rem=%0d busy=%b done=%b wrap=%b, want all 0",
               address, remaining, busy, doneP, wrapP);
    end
    n_checks++;
    @(posedge clk); #1;
    if ({address, remaining, busy, doneP, wrapP} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_hold: addr=%h rem=%0d busy=%b done=%b wrap=%b, want all 0",
               address, remaining, busy, doneP, wrapP);
    end
    n_checks++;
    @(negedge clk);
    incP = 1'b0;
    rst_n = 1'b1;
    model_reset();
    idle();
    if ({address, doneP} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_release: addr=%h done=%b, want 0 0", address, doneP);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [AW-1:0] la;
    bit            b_init, b_load, b_start, b_inc;
    logic [LW-1:0] len;
    int            errs = 0;
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       limit = '0;
        1:       limit = 24'h000200;
        2:       limit = AW'($urandom_range(24'h001000, 24'hFFFFFF));
        default: limit = 24'h000105;
      endcase
      wrap_base = (limit == '0) ? AW'($urandom) : AW'($urandom_range(0, int'(limit) - 1));
      for (int c = 0; c < 150; c++) begin
        b_init  = ($urandom_range(0, 99) < 2);
        b_load  = ($urandom_range(0, 99) < 5);
        b_start = ($urandom_range(0, 9) == 0);
        b_inc   = ($urandom_range(0, 3) != 0);
        len     = LW'($urandom_range(0, 6));
        la      = (limit == '0) ? AW'($urandom) : AW'(int'(limit) - $urandom_range(1, 64));
        step(b_init, b_load, la, b_start, len, b_inc);
        if (address !== AW'(m_addr)) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_addr seg%0d cyc%0d: got %h want %h",
                                  seg, c, address, AW'(m_addr));
        end
        n_checks++;
        if ({remaining, busy, doneP, wrapP} !== {LW'(m_rem), m_running, m_finished, m_wrap}) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_ctrl seg%0d cyc%0d: rem/busy/done/wrap=%0d/%b/%b/%b want %0d/%b/%b/%b",
                                  seg, c, remaining, busy, doneP, wrapP,
                                  m_rem, m_running, m_finished, m_wrap);
        end
        n_checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_inc();
    test_burst();
    test_wrap_limit();
    test_wrap_modulo();
    test_priority();
    test_abort_init();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
